// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle core's unified
// instruction/data port. A request (MemRead|MemWrite) seen in IDLE is
// latched, held for WAIT_CYCLES wait states, then performed on the edge that
// enters RESP. RESP raises Ready for exactly one cycle.
//
// Parameters:
//   DEPTH       number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES wait states between acceptance and response (0..15)
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   MemRead    read request, held until Ready
//   MemWrite   write request, held until Ready (wins over MemRead)
//   Adr        byte address; word index = Adr[log2(DEPTH)+1:2]
//   WriteData  store data
//   ReadData   registered read data, holds until the next completed read
//   Ready      one-cycle completion pulse
//   Fault      misaligned-access flag (only with the alignment check)
// Optional feature:
//   MEM_RESPONDER_ALIGN_CHECK_EN - when defined, a request with Adr[1:0]!=0
//   does no array access, clears ReadData and raises Fault with Ready.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Fault
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WC        = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               lat_wr;
  logic [IDX_W-1:0]   lat_idx;
  logic [31:0]        lat_wdata;
  logic [31:0]        mem [DEPTH];

  logic               req, start, enter_resp, acc_wr, mis;
  logic [IDX_W-1:0]   acc_idx;
  logic [31:0]        acc_wdata;

  assign req   = MemRead | MemWrite;
  assign start = (state == ST_IDLE) && req;

  // With zero wait states the access happens on the accepting edge itself,
  // so the live inputs are used; otherwise the latched copies are used.
  assign enter_resp = (start && ZERO_WAIT) || ((state == ST_WAIT) && (cnt == 4'd1));
  assign acc_wr     = (state == ST_IDLE) ? MemWrite           : lat_wr;
  assign acc_idx    = (state == ST_IDLE) ? Adr[IDX_W+1:2]     : lat_idx;
  assign acc_wdata  = (state == ST_IDLE) ? WriteData          : lat_wdata;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic [1:0] lat_lo, acc_lo;
  logic       fault_q;
  assign acc_lo = (state == ST_IDLE) ? Adr[1:0] : lat_lo;
  assign mis    = (acc_lo != 2'b00);
  assign Fault  = fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_lo  <= 2'b00;
      fault_q <= 1'b0;
    end else begin
      fault_q <= enter_resp && mis;
      if (start) lat_lo <= Adr[1:0];
    end
  end

  logic unused_adr;
  assign unused_adr = ^Adr[31:IDX_W+2];
`else
  assign mis   = 1'b0;
  assign Fault = 1'b0;

  logic unused_adr;
  assign unused_adr = ^{Adr[31:IDX_W+2], Adr[1:0]};
`endif

  // Control, latches and read data. Array contents are not reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      Ready     <= 1'b0;
      ReadData  <= '0;
      lat_wr    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else begin
      Ready <= 1'b0;
      if (enter_resp) begin
        Ready <= 1'b1;
        if (mis)          ReadData <= '0;
        else if (!acc_wr) ReadData <= mem[acc_idx];
      end
      case (state)
        ST_IDLE: if (req) begin
          lat_wr    <= MemWrite;
          lat_idx   <= Adr[IDX_W+1:2];
          lat_wdata <= WriteData;
          if (ZERO_WAIT) state <= ST_RESP;
          else begin
            cnt   <= WC;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gated by reset so an edge while reset is held never commits a write.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_wr && !mis) mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] Adr = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        Ready, Fault;

  logic        MemRead0 = 1'b0, MemWrite0 = 1'b0;
  logic [31:0] Adr0 = '0, WriteData0 = '0;
  logic [31:0] ReadData0;
  logic        Ready0, Fault0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
    .Ready(Ready), .Fault(Fault));

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .MemRead(MemRead0), .MemWrite(MemWrite0),
    .Adr(Adr0), .WriteData(WriteData0), .ReadData(ReadData0),
    .Ready(Ready0), .Fault(Fault0));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request on the WAIT_CYCLES=2 instance; inputs other than the
  // request strobes are scrambled after acceptance to prove they are latched.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, output int lat);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Adr = a; WriteData = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin Adr = 32'h0000_003C; WriteData = 32'h5A5A_5A5A; end
    end while (!Ready && lat < 20);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int lat;
    txn(vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].wdata, lat);
    chk($sformatf("v%0d_ready", i), {31'b0, Ready}, 32'd1);
    chk($sformatf("v%0d_latency", i), lat, 32'd3);
    chk($sformatf("v%0d_rdata", i), ReadData, vecs[i].exp_rdata);
    chk($sformatf("v%0d_fault", i), {31'b0, Fault}, {31'b0, vecs[i].exp_fault});
    @(posedge clk); #1;
    chk($sformatf("v%0d_ready_drop", i), {31'b0, Ready}, 32'd0);
    chk($sformatf("v%0d_fault_drop", i), {31'b0, Fault}, 32'd0);
  endtask

  initial begin
    int lat;
    //          rd    wr    adr            wdata          exp_rdata     fault
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0100, 32'hAAAA_5555, 32'hCAFE_F00D, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hAAAA_5555, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, 32'hAAAA_5555, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1111_1111, 1'b0};
    // after the mid-WAIT reset: the aborted write must not have landed
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1111_1111, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_000A, 32'h9999_9999,
                 ALIGN ? 32'h0 : 32'h1111_1111, ALIGN};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,
                 ALIGN ? 32'h1111_1111 : 32'h9999_9999, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_000B, 32'h0,
                 ALIGN ? 32'h0 : 32'h9999_9999, ALIGN};

    // reset state, checked while reset is still low
    #12;
    chk("rst_ready", {31'b0, Ready}, 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_fault", {31'b0, Fault}, 32'd0);
    chk("rst_ready0", {31'b0, Ready0}, 32'd0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // reset in the first WAIT cycle of a write to word 2
    @(negedge clk);
    MemWrite = 1'b1; Adr = 32'h0000_0008; WriteData = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    chk("midwait_ready", {31'b0, Ready}, 32'd0);
    chk("midwait_rdata", ReadData, 32'd0);
    MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;

    // reset during the Ready cycle drops Ready without a clock edge
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat);
    chk("rstresp_ready_before", {31'b0, Ready}, 32'd1);
    chk("rstresp_rdata_before", ReadData, 32'h1234_5678);
    #1 reset = 1'b0; #1;
    chk("rstresp_ready_after", {31'b0, Ready}, 32'd0);
    chk("rstresp_rdata_after", ReadData, 32'd0);
    @(negedge clk); reset = 1'b1;

    for (int i = 8; i < 12; i++) run_vec(i);

    // zero wait states: Ready in the cycle right after the accepting edge
    @(negedge clk);
    MemWrite0 = 1'b1; Adr0 = 32'h0000_0020; WriteData0 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("zw_write_ready", {31'b0, Ready0}, 32'd1);
    chk("zw_write_rdata", ReadData0, 32'd0);
    MemWrite0 = 1'b0;
    @(posedge clk); #1;
    chk("zw_idle_ready", {31'b0, Ready0}, 32'd0);
    // held MemRead: Ready every other cycle
    MemRead0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("zw_held_ready%0d", k), {31'b0, Ready0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) chk($sformatf("zw_held_rdata%0d", k), ReadData0, 32'hDEAD_BEEF);
    end
    MemRead0 = 1'b0;
    chk("zw_fault", {31'b0, Fault0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle ARM core's unified instruction/data memory port.
- Accepts read and write requests from the processor's address/data/MemWrite outputs, inserts a programmable number of wait states, and performs the access.
- Returns read data with a one-cycle Ready pulse, so the controller FSM can stall on slow memory instead of assuming single-cycle access.

Parameters:
- DEPTH, 64, number of 32-bit words; must be a power of two ≥ 2.
- WAIT_CYCLES, 2, wait states inserted between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemRead  input  1  read request; held until Ready.
- MemWrite  input  1  write request; held until Ready.
- Adr  input  32  byte address; word index is Adr[log2(DEPTH)+1:2].
- WriteData  input  32  store data.
- ReadData  output  32  registered read data.
- Ready  output  1  one-cycle completion pulse.
- Fault  output  1  misaligned-access flag; functional only with the optional feature.

Behaviour:
- Reset (reset=0, asynchronous) forces the following, with no clock edge required:
  - state=IDLE, Ready=0, ReadData=0, Fault=0, wait counter=0.
  - Array contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request is MemRead|MemWrite sampled at a rising edge. On a request, latch Adr, WriteData and kind into internal registers.
  - If both MemRead and MemWrite are high, the transaction is a write; ReadData is unchanged.
  - If WAIT_CYCLES=0, go to RESP; otherwise load counter=WAIT_CYCLES and go to WAIT.
- WAIT:
  - Decrement counter each edge; when counter=1 at an edge, go to RESP.
  - Input changes during WAIT are ignored; the latched values are used.
- Access timing: the access is performed on the edge entering RESP.
  - Write: mem[idx] <= latched WriteData.
  - Read: ReadData <= mem[idx].
- RESP:
  - Ready=1 for exactly this one cycle, then unconditionally go to IDLE.
- Latency: the request is accepted at edge t0; Ready is high in the cycle after edge t0+WAIT_CYCLES. With WAIT_CYCLES=2, Ready is high 3 cycles after acceptance.
- Throughput: a request still high in the IDLE cycle after RESP is accepted as a new transaction. The requester must drop its request in the Ready cycle if it wants no repeat. Minimum spacing is WAIT_CYCLES+2 cycles per transaction.
- ReadData holds its value until the next completed read; it does not return to 0 between reads.
- Address wrap: word index is taken modulo DEPTH. Adr bits above the index and Adr[1:0] are ignored (feature off).
- Reset mid-transaction (in WAIT or RESP): abort immediately. A pending write is discarded and the array is not modified. Ready drops asynchronously.
- Read-after-write to the same word in consecutive transactions returns the newly written data.

Optional Feature:
- Macro: MEM_RESPONDER_ALIGN_CHECK_EN.
- Defined:
  - A request with latched Adr[1:0]≠0 performs no array access; the write is suppressed and ReadData is set to 0.
  - Fault=1 together with Ready in the RESP cycle; Fault is 0 in all other cycles.
  - Wait-state timing is unchanged.
- Undefined:
  - Fault is tied to 0 and Adr[1:0] is ignored (access goes to the word index).

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write 0x12345678 to Adr 0x10; Ready rises 3 cycles after acceptance.
  - Read from Adr 0x10; ReadData=0x12345678 in its Ready cycle.
- Zero wait states, WAIT_CYCLES=0:
  - Read accepted at edge t0 gives Ready=1 in the cycle after t0.
  - With MemRead held continuously, Ready pulses every 2 cycles.
- Simultaneous MemRead=MemWrite=1:
  - Write 0xCAFEF00D to Adr 0x04; ReadData keeps its prior value.
  - A subsequent read of 0x04 returns 0xCAFEF00D.
- Wrap, DEPTH=64:
  - Write 0xAAAA5555 to Adr 0x100 (index 64 → 0).
  - Read Adr 0x000 returns 0xAAAA5555.
- Reset mid-WAIT:
  - Write 0xFFFFFFFF to Adr 0x08 over prior contents 0x11111111; assert reset in the first WAIT cycle.
  - Ready=0 and ReadData=0 immediately; after release, reading 0x08 returns 0x11111111.
- Misaligned access, MEM_RESPONDER_ALIGN_CHECK_EN defined:
  - Write 0x99999999 to Adr 0x0A: Fault=1 with Ready, and word 0x08 is unchanged.
  - With the macro undefined: Fault=0, and word 0x08 becomes 0x99999999.
